tl_source_limiter: RTL and testbench

TL_SOURCE_LIMITER -- requirements
Module: tl_source_limiter

---
 rtl/tl_pkg.sv | 38 +++
 rtl/tl_beat_counter.sv | 38 +++
 rtl/tl_source_limiter.sv | 157 +++++++++++++++
 tb/tb_tl_source_limiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// TileLink opcode constants and burst-length helpers shared by the
// source limiter and its beat counters.
package tl_pkg;

   localparam logic [2:0] A_PUT_FULL    = 3'd0;
   localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] A_ARITHMETIC  = 3'd2;
   localparam logic [2:0] A_LOGICAL     = 3'd3;
   localparam logic [2:0] A_GET         = 3'd4;
   localparam logic [2:0] A_INTENT      = 3'd5;

   localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
   localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
   localparam logic [2:0] D_HINT_ACK        = 3'd2;

   localparam logic [3:0] MAX_SIZE   = 4'd6;
   localparam int         BEAT_CNT_W = 8;

   function automatic logic a_has_data(input logic [2:0] op);
      return ~op[2];
   endfunction

   function automatic logic d_has_data(input logic [2:0] op);
      return op[0];
   endfunction

   // Oversized requests are clamped so the counter stays bounded.
   function automatic logic [BEAT_CNT_W-1:0] beats_from_size(
      input logic [3:0] size,
      input logic [3:0] log2_bb
   );
      logic [3:0] s;
      s = (size > MAX_SIZE) ? MAX_SIZE : size;
      if (s > log2_bb) return BEAT_CNT_W'(1) << (s - log2_bb);
      return BEAT_CNT_W'(1);
   endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Tracks the position inside a multi-beat TileLink message and flags
// the first and last beats.
module tl_beat_counter
   import tl_pkg::*;
#(
   parameter int LOG2_BB = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       fire,
   input  logic       has_data,
   input  logic [3:0] size,
   output logic       first,
   output logic       last
);

   localparam logic [3:0] LOG2_BB_W = 4'(LOG2_BB);

   logic [BEAT_CNT_W-1:0] cnt_q;
   logic [BEAT_CNT_W-1:0] cnt_d;
   logic [BEAT_CNT_W-1:0] beats;

   assign beats = has_data ? beats_from_size(size, LOG2_BB_W)
                           : BEAT_CNT_W'(1);
   assign first = (cnt_q == '0);
   assign last  = (cnt_q == beats - BEAT_CNT_W'(1));

   always_comb begin
      cnt_d = cnt_q;
      if (fire) cnt_d = last ? '0 : cnt_q + BEAT_CNT_W'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/tl_source_limiter.sv
// Allows one outstanding A request per source and caps the total
// outstanding count; D traffic passes straight through.
module tl_source_limiter
   import tl_pkg::*;
#(
   parameter int MAX_INFLIGHT = 8,
   parameter int SOURCE_BITS  = 4,
   parameter int BEAT_BYTES   = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   output logic                      auto_in_a_ready,
   input  logic                      auto_in_a_valid,
   input  logic [2:0]                auto_in_a_bits_opcode,
   input  logic [2:0]                auto_in_a_bits_param,
   input  logic [3:0]                auto_in_a_bits_size,
   input  logic [SOURCE_BITS-1:0]    auto_in_a_bits_source,
   input  logic [32:0]               auto_in_a_bits_address,
   input  logic [BEAT_BYTES-1:0]     auto_in_a_bits_mask,
   input  logic [8*BEAT_BYTES-1:0]   auto_in_a_bits_data,
   input  logic                      auto_in_a_bits_corrupt,
   input  logic                      auto_out_a_ready,
   output logic                      auto_out_a_valid,
   output logic [2:0]                auto_out_a_bits_opcode,
   output logic [2:0]                auto_out_a_bits_param,
   output logic [3:0]                auto_out_a_bits_size,
   output logic [SOURCE_BITS-1:0]    auto_out_a_bits_source,
   output logic [32:0]               auto_out_a_bits_address,
   output logic [BEAT_BYTES-1:0]     auto_out_a_bits_mask,
   output logic [8*BEAT_BYTES-1:0]   auto_out_a_bits_data,
   output logic                      auto_out_a_bits_corrupt,
   output logic                      auto_out_d_ready,
   input  logic                      auto_out_d_valid,
   input  logic [2:0]                auto_out_d_bits_opcode,
   input  logic [1:0]                auto_out_d_bits_param,
   input  logic [3:0]                auto_out_d_bits_size,
   input  logic [SOURCE_BITS-1:0]    auto_out_d_bits_source,
   input  logic [1:0]                auto_out_d_bits_sink,
   input  logic                      auto_out_d_bits_denied,
   input  logic [8*BEAT_BYTES-1:0]   auto_out_d_bits_data,
   input  logic                      auto_out_d_bits_corrupt,
   input  logic                      auto_in_d_ready,
   output logic                      auto_in_d_valid,
   output logic [2:0]                auto_in_d_bits_opcode,
   output logic [1:0]                auto_in_d_bits_param,
   output logic [3:0]                auto_in_d_bits_size,
   output logic [SOURCE_BITS-1:0]    auto_in_d_bits_source,
   output logic [1:0]                auto_in_d_bits_sink,
   output logic                      auto_in_d_bits_denied,
   output logic [8*BEAT_BYTES-1:0]   auto_in_d_bits_data,
   output logic                      auto_in_d_bits_corrupt,
   output logic [4:0]                io_inflight,
   output logic                      io_error
);

   localparam int         NSRC    = 1 << SOURCE_BITS;
   localparam int         LOG2_BB = $clog2(BEAT_BYTES);
   localparam logic [4:0] MAX_CNT = 5'(MAX_INFLIGHT);

   logic [NSRC-1:0] busy_q, busy_d;
   logic [4:0]      inflight_q, inflight_d;
   logic            error_q, error_d;

   logic a_first, a_last, d_first, d_last;
   logic block, a_fire, d_fire;
   logic a_take, d_free, d_bad, size_err;
   logic unused_ok;

   assign auto_out_a_bits_opcode  = auto_in_a_bits_opcode;
   assign auto_out_a_bits_param   = auto_in_a_bits_param;
   assign auto_out_a_bits_size    = auto_in_a_bits_size;
   assign auto_out_a_bits_source  = auto_in_a_bits_source;
   assign auto_out_a_bits_address = auto_in_a_bits_address;
   assign auto_out_a_bits_mask    = auto_in_a_bits_mask;
   assign auto_out_a_bits_data    = auto_in_a_bits_data;
   assign auto_out_a_bits_corrupt = auto_in_a_bits_corrupt;

   assign auto_in_d_valid        = auto_out_d_valid;
   assign auto_out_d_ready       = auto_in_d_ready;
   assign auto_in_d_bits_opcode  = auto_out_d_bits_opcode;
   assign auto_in_d_bits_param   = auto_out_d_bits_param;
   assign auto_in_d_bits_size    = auto_out_d_bits_size;
   assign auto_in_d_bits_source  = auto_out_d_bits_source;
   assign auto_in_d_bits_sink    = auto_out_d_bits_sink;
   assign auto_in_d_bits_denied  = auto_out_d_bits_denied;
   assign auto_in_d_bits_data    = auto_out_d_bits_data;
   assign auto_in_d_bits_corrupt = auto_out_d_bits_corrupt;

   // Only the head beat of a message can be held back.
   assign block = a_first
                & (busy_q[auto_in_a_bits_source] | (inflight_q == MAX_CNT));

   assign auto_out_a_valid = auto_in_a_valid & ~block & ~reset;
   assign auto_in_a_ready  = auto_out_a_ready & ~block;

   assign a_fire = auto_out_a_valid & auto_out_a_ready;
   assign d_fire = auto_out_d_valid & auto_in_d_ready;

   tl_beat_counter #(.LOG2_BB(LOG2_BB)) u_a_cnt (
      .clock    (clock),
      .reset    (reset),
      .fire     (a_fire),
      .has_data (a_has_data(auto_in_a_bits_opcode)),
      .size     (auto_in_a_bits_size),
      .first    (a_first),
      .last     (a_last)
   );

   tl_beat_counter #(.LOG2_BB(LOG2_BB)) u_d_cnt (
      .clock    (clock),
      .reset    (reset),
      .fire     (d_fire),
      .has_data (d_has_data(auto_out_d_bits_opcode)),
      .size     (auto_out_d_bits_size),
      .first    (d_first),
      .last     (d_last)
   );

   assign unused_ok = ^{a_last, d_first};

   assign a_take = a_fire & a_first;
   assign d_free = d_fire & d_last & busy_q[auto_out_d_bits_source];
   assign d_bad  = d_fire & d_last & ~busy_q[auto_out_d_bits_source];

   assign size_err =
        (auto_in_a_valid  & (auto_in_a_bits_size  > MAX_SIZE))
      | (auto_out_d_valid & (auto_out_d_bits_size > MAX_SIZE));

   always_comb begin
      busy_d     = busy_q;
      inflight_d = inflight_q;
      error_d    = error_q | d_bad | size_err;
      if (d_free) busy_d[auto_out_d_bits_source] = 1'b0;
      if (a_take) busy_d[auto_in_a_bits_source]  = 1'b1;
      unique case ({a_take, d_free})
         2'b10:   inflight_d = inflight_q + 5'd1;
         2'b01:   inflight_d = inflight_q - 5'd1;
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy_q     <= '0;
         inflight_q <= '0;
         error_q    <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         inflight_q <= inflight_d;
         error_q    <= error_d;
      end
   end

   assign io_inflight = inflight_q;
   assign io_error    = error_q;

endmodule

// File: tb/tb_tl_source_limiter.sv
// Randomized and directed checks of tl_source_limiter against a
// message-level model of outstanding sources.
module tb_tl_source_limiter;
   import tl_pkg::*;

   localparam int MAXI = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic        a_valid = 0, oa_ready = 0;
   logic [2:0]  a_op = 0, a_param = 0;
   logic [3:0]  a_size = 0, a_src = 0;
   logic [32:0] a_addr = 0;
   logic [7:0]  a_mask = 0;
   logic [63:0] a_data = 0;
   logic        a_corrupt = 0;
   logic        d_valid = 0, id_ready = 0;
   logic [2:0]  d_op = 0;
   logic [1:0]  d_param = 0, d_sink = 0;
   logic [3:0]  d_size = 0, d_src = 0;
   logic        d_denied = 0, d_corrupt = 0;
   logic [63:0] d_data = 0;

   logic        ia_ready, oa_valid, od_ready, id_valid;
   logic [2:0]  oa_op, oa_param, id_op;
   logic [3:0]  oa_size, oa_src, id_size, id_src;
   logic [32:0] oa_addr;
   logic [7:0]  oa_mask;
   logic [63:0] oa_data, id_data;
   logic        oa_corrupt, id_denied, id_corrupt;
   logic [1:0]  id_param, id_sink;
   logic [4:0]  io_inflight;
   logic        io_error;

   int checks = 0;
   int errors = 0;

   tl_source_limiter dut (
      .clock(clock), .reset(reset),
      .auto_in_a_ready(ia_ready), .auto_in_a_valid(a_valid),
      .auto_in_a_bits_opcode(a_op), .auto_in_a_bits_param(a_param),
      .auto_in_a_bits_size(a_size), .auto_in_a_bits_source(a_src),
      .auto_in_a_bits_address(a_addr), .auto_in_a_bits_mask(a_mask),
      .auto_in_a_bits_data(a_data), .auto_in_a_bits_corrupt(a_corrupt),
      .auto_out_a_ready(oa_ready), .auto_out_a_valid(oa_valid),
      .auto_out_a_bits_opcode(oa_op), .auto_out_a_bits_param(oa_param),
      .auto_out_a_bits_size(oa_size), .auto_out_a_bits_source(oa_src),
      .auto_out_a_bits_address(oa_addr), .auto_out_a_bits_mask(oa_mask),
      .auto_out_a_bits_data(oa_data), .auto_out_a_bits_corrupt(oa_corrupt),
      .auto_out_d_ready(od_ready), .auto_out_d_valid(d_valid),
      .auto_out_d_bits_opcode(d_op), .auto_out_d_bits_param(d_param),
      .auto_out_d_bits_size(d_size), .auto_out_d_bits_source(d_src),
      .auto_out_d_bits_sink(d_sink), .auto_out_d_bits_denied(d_denied),
      .auto_out_d_bits_data(d_data), .auto_out_d_bits_corrupt(d_corrupt),
      .auto_in_d_ready(id_ready), .auto_in_d_valid(id_valid),
      .auto_in_d_bits_opcode(id_op), .auto_in_d_bits_param(id_param),
      .auto_in_d_bits_size(id_size), .auto_in_d_bits_source(id_src),
      .auto_in_d_bits_sink(id_sink), .auto_in_d_bits_denied(id_denied),
      .auto_in_d_bits_data(id_data), .auto_in_d_bits_corrupt(id_corrupt),
      .io_inflight(io_inflight), .io_error(io_error)
   );

   // Reference model: set of outstanding sources, position in bursts.
   bit m_busy [16];
   int m_infl = 0;
   bit m_err  = 0;
   int m_aidx = 0;
   int m_didx = 0;

   function automatic int n_beats(bit has_data, logic [3:0] size);
      int s;
      s = (size > 6) ? 6 : int'(size);
      if (has_data && s > 3) return 2 ** (s - 3);
      return 1;
   endfunction

   function automatic bit exp_block();
      return (m_aidx == 0) && (m_busy[a_src] || m_infl == MAXI);
   endfunction

   always @(posedge clock or posedge reset) begin
      bit af, df, dlast;
      if (reset) begin
         foreach (m_busy[i]) m_busy[i] = 0;
         m_infl = 0; m_err = 0; m_aidx = 0; m_didx = 0;
      end else begin
         af = a_valid && oa_ready && !exp_block();
         df = d_valid && id_ready;
         dlast = (m_didx == n_beats(d_op[0], d_size) - 1);
         if ((a_valid && a_size > 6) || (d_valid && d_size > 6)) m_err = 1;
         if (df && dlast) begin
            if (m_busy[d_src]) begin
               m_busy[d_src] = 0; m_infl--;
            end else m_err = 1;
         end
         if (af && m_aidx == 0) begin
            m_busy[a_src] = 1; m_infl++;
         end
         if (af) m_aidx = (m_aidx + 1) % n_beats(!a_op[2], a_size);
         if (df) m_didx = dlast ? 0 : m_didx + 1;
      end
   end

   task automatic tick;
      @(posedge clock); #1;
   endtask

   task automatic set_a(bit v, logic [2:0] op, logic [3:0] sz, logic [3:0] src);
      a_valid = v; a_op = op; a_size = sz; a_src = src;
      a_param = 3'($urandom); a_addr = {1'b0, $urandom};
      a_mask = 8'($urandom); a_data = {$urandom, $urandom};
      a_corrupt = 1'($urandom);
   endtask

   task automatic set_d(bit v, logic [2:0] op, logic [3:0] sz, logic [3:0] src);
      d_valid = v; d_op = op; d_size = sz; d_src = src;
      d_param = 2'($urandom); d_sink = 2'($urandom);
      d_denied = 1'($urandom); d_corrupt = 1'($urandom);
      d_data = {$urandom, $urandom};
   endtask

   task automatic issue_a(logic [2:0] op, logic [3:0] sz, logic [3:0] src);
      oa_ready = 1;
      repeat (n_beats(!op[2], sz)) begin
         set_a(1, op, sz, src); tick;
      end
      a_valid = 0;
   endtask

   task automatic respond(logic [2:0] op, logic [3:0] sz, logic [3:0] src);
      id_ready = 1;
      repeat (n_beats(op[0], sz)) begin
         set_d(1, op, sz, src); tick;
      end
      d_valid = 0;
   endtask

   task automatic test_reset;
      set_a(1, A_GET, 3, 1); oa_ready = 1;
      set_d(1, D_ACCESS_ACK, 0, 1); id_ready = 1;
      #1;
      checks++; if (io_inflight !== 5'd0) begin errors++;
         $display("FAIL reset_inflight: got %0d want 0", io_inflight); end
      checks++; if (io_error !== 1'b0) begin errors++;
         $display("FAIL reset_error: got %0b want 0", io_error); end
      checks++; if (oa_valid !== 1'b0) begin errors++;
         $display("FAIL reset_oa_valid: got %0b want 0", oa_valid); end
      checks++; if (oa_data !== a_data || id_data !== d_data) begin errors++;
         $display("FAIL reset_passthru: got %h/%h want %h/%h",
                  oa_data, id_data, a_data, d_data); end
      checks++; if (id_valid !== 1'b1 || od_ready !== 1'b1) begin errors++;
         $display("FAIL reset_d_hs: got %0b/%0b want 1/1", id_valid, od_ready); end
      a_valid = 0; d_valid = 0;
      tick; tick; reset = 0; tick;
   endtask

   task automatic test_same_source;
      set_a(1, A_GET, 3, 2); oa_ready = 1; #1;
      checks++; if (oa_valid !== 1'b1 || ia_ready !== 1'b1) begin errors++;
         $display("FAIL get1_pass: got v%0b r%0b want 1/1", oa_valid, ia_ready); end
      tick;
      set_a(1, A_GET, 3, 2); #1;
      checks++; if (ia_ready !== 1'b0 || oa_valid !== 1'b0) begin errors++;
         $display("FAIL get2_block: got r%0b v%0b want 0/0", ia_ready, oa_valid); end
      checks++; if (io_inflight !== 5'd1) begin errors++;
         $display("FAIL get1_inflight: got %0d want 1", io_inflight); end
      repeat (3) begin
         tick;
         checks++; if (ia_ready !== 1'b0) begin errors++;
            $display("FAIL get2_hold: got %0b want 0", ia_ready); end
      end
      set_d(1, D_ACCESS_ACK_DATA, 3, 2); id_ready = 1; #1;
      checks++; if (ia_ready !== 1'b0) begin errors++;
         $display("FAIL get2_same_cycle: got %0b want 0", ia_ready); end
      checks++; if (id_valid !== 1'b1 || id_data !== d_data || id_src !== 4'd2) begin errors++;
         $display("FAIL d_passthru: got v%0b %h s%0d want 1 %h s2",
                  id_valid, id_data, id_src, d_data); end
      tick; d_valid = 0; #1;
      checks++; if (ia_ready !== 1'b1 || oa_valid !== 1'b1) begin errors++;
         $display("FAIL get2_release: got r%0b v%0b want 1/1", ia_ready, oa_valid); end
      checks++; if (io_inflight !== 5'd0) begin errors++;
         $display("FAIL get1_freed: got %0d want 0", io_inflight); end
      tick; a_valid = 0; #1;
      checks++; if (io_inflight !== 5'd1) begin errors++;
         $display("FAIL get2_inflight: got %0d want 1", io_inflight); end
      respond(D_ACCESS_ACK_DATA, 3, 2);
   endtask

   task automatic test_max_inflight;
      for (int i = 0; i < 8; i++) begin
         set_a(1, A_GET, 3, 4'(i)); oa_ready = 1; tick;
      end
      set_a(1, A_GET, 3, 8); #1;
      checks++; if (io_inflight !== 5'd8) begin errors++;
         $display("FAIL max_count: got %0d want 8", io_inflight); end
      checks++; if (ia_ready !== 1'b0 || oa_valid !== 1'b0) begin errors++;
         $display("FAIL max_block: got r%0b v%0b want 0/0", ia_ready, oa_valid); end
      tick;
      set_d(1, D_ACCESS_ACK_DATA, 3, 0); id_ready = 1; #1;
      checks++; if (ia_ready !== 1'b0) begin errors++;
         $display("FAIL max_block_dcycle: got %0b want 0", ia_ready); end
      tick; d_valid = 0; #1;
      checks++; if (ia_ready !== 1'b1 || oa_valid !== 1'b1) begin errors++;
         $display("FAIL max_ninth: got r%0b v%0b want 1/1", ia_ready, oa_valid); end
      tick; a_valid = 0; #1;
      checks++; if (io_inflight !== 5'd8) begin errors++;
         $display("FAIL max_after: got %0d want 8", io_inflight); end
      for (int i = 1; i <= 8; i++) respond(D_ACCESS_ACK_DATA, 3, 4'(i));
      #1;
      checks++; if (io_inflight !== 5'd0) begin errors++;
         $display("FAIL max_drain: got %0d want 0", io_inflight); end
   endtask

   task automatic test_putfull_burst;
      int fired = 0;
      int cyc = 0;
      while (fired < 8 && cyc < 200) begin
         set_a(1, A_PUT_FULL, 6, 3);
         oa_ready = 1'($urandom_range(0, 1)); #1;
         checks++; if (oa_valid !== 1'b1 || oa_data !== a_data || ia_ready !== oa_ready) begin
            errors++;
            $display("FAIL put_beat%0d: got v%0b r%0b %h want 1 r%0b %h",
                     fired, oa_valid, ia_ready, oa_data, oa_ready, a_data);
         end
         checks++; if (io_inflight !== ((fired > 0) ? 5'd1 : 5'd0)) begin errors++;
            $display("FAIL put_inflight%0d: got %0d want %0d",
                     fired, io_inflight, (fired > 0) ? 1 : 0); end
         if (oa_ready) fired++;
         tick; cyc++;
      end
      a_valid = 0;
      checks++; if (fired != 8) begin errors++;
         $display("FAIL put_beats: got %0d want 8", fired); end
      set_a(1, A_GET, 3, 3); oa_ready = 1; #1;
      checks++; if (ia_ready !== 1'b0 || io_inflight !== 5'd1) begin errors++;
         $display("FAIL put_busy: got r%0b n%0d want 0/1", ia_ready, io_inflight); end
      a_valid = 0;
      respond(D_ACCESS_ACK, 6, 3);
   endtask

   task automatic test_d_burst;
      issue_a(A_GET, 6, 4);
      for (int b = 0; b < 8; b++) begin
         set_d(1, D_ACCESS_ACK_DATA, 6, 4); id_ready = 1; #1;
         checks++; if (io_inflight !== 5'd1 || id_data !== d_data) begin errors++;
            $display("FAIL dburst_beat%0d: got n%0d %h want 1 %h",
                     b, io_inflight, id_data, d_data); end
         tick;
      end
      d_valid = 0;
      set_a(1, A_GET, 3, 4); oa_ready = 1; #1;
      checks++; if (io_inflight !== 5'd0 || ia_ready !== 1'b1) begin errors++;
         $display("FAIL dburst_release: got n%0d r%0b want 0/1", io_inflight, ia_ready); end
      a_valid = 0;
   endtask

   task automatic test_error;
      issue_a(A_GET, 3, 1);
      set_d(1, D_ACCESS_ACK, 0, 5); id_ready = 1;
      tick; d_valid = 0; #1;
      checks++; if (io_error !== 1'b1 || io_inflight !== 5'd1) begin errors++;
         $display("FAIL err_set: got e%0b n%0d want 1/1", io_error, io_inflight); end
      repeat (3) tick;
      respond(D_ACCESS_ACK, 0, 1); #1;
      checks++; if (io_error !== 1'b1 || io_inflight !== 5'd0) begin errors++;
         $display("FAIL err_sticky: got e%0b n%0d want 1/0", io_error, io_inflight); end
      reset = 1; #1;
      checks++; if (io_error !== 1'b0) begin errors++;
         $display("FAIL err_reset: got %0b want 0", io_error); end
      tick; reset = 0;
      set_a(1, A_GET, 7, 9); oa_ready = 0; #1;
      checks++; if (io_error !== 1'b0) begin errors++;
         $display("FAIL size_err_early: got %0b want 0", io_error); end
      tick; a_valid = 0; #1;
      checks++; if (io_error !== 1'b1) begin errors++;
         $display("FAIL size_err: got %0b want 1", io_error); end
      reset = 1; tick; reset = 0;
   endtask

   task automatic test_reset_mid_burst;
      oa_ready = 1;
      repeat (3) begin set_a(1, A_PUT_FULL, 6, 6); tick; end
      set_a(1, A_PUT_FULL, 6, 6); #1;
      checks++; if (io_inflight !== 5'd1) begin errors++;
         $display("FAIL midrst_pre: got %0d want 1", io_inflight); end
      reset = 1; #1;
      checks++; if (io_inflight !== 5'd0 || io_error !== 1'b0 || oa_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_now: got n%0d e%0b v%0b want 0/0/0",
                  io_inflight, io_error, oa_valid);
      end
      checks++; if (oa_data !== a_data) begin errors++;
         $display("FAIL midrst_passthru: got %h want %h", oa_data, a_data); end
      tick; reset = 0;
      set_a(1, A_GET, 3, 6); #1;
      checks++; if (oa_valid !== 1'b1 || ia_ready !== 1'b1) begin errors++;
         $display("FAIL midrst_newget: got v%0b r%0b want 1/1", oa_valid, ia_ready); end
      tick; a_valid = 0; #1;
      checks++; if (io_inflight !== 5'd1 || io_error !== 1'b0) begin errors++;
         $display("FAIL midrst_after: got n%0d e%0b want 1/0", io_inflight, io_error); end
      respond(D_ACCESS_ACK_DATA, 3, 6);
   endtask

   task automatic test_random;
      int a_left = 0, d_left = 0;
      logic [2:0] ro_a, ro_d;
      logic [3:0] rs_a, rs_d, rsrc_a, rsrc_d;
      int cand [$];
      bit blk, af, df;
      for (int c = 0; c < 800; c++) begin
         if (a_left == 0 && $urandom_range(0, 2) == 0) begin
            ro_a = $urandom_range(0, 1) ? A_PUT_FULL : A_GET;
            rs_a = 4'($urandom_range(0, 6));
            rsrc_a = 4'($urandom_range(0, 15));
            a_left = n_beats(!ro_a[2], rs_a);
         end
         if (a_left > 0) set_a(1, ro_a, rs_a, rsrc_a);
         else a_valid = 0;
         oa_ready = ($urandom_range(0, 3) != 0);
         if (d_left == 0) begin
            cand.delete();
            foreach (m_busy[i]) if (m_busy[i]) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 1)) begin
               rsrc_d = 4'(cand[$urandom_range(0, cand.size() - 1)]);
               ro_d = $urandom_range(0, 1) ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
               rs_d = 4'($urandom_range(0, 6));
               d_left = n_beats(ro_d[0], rs_d);
            end
         end
         if (d_left > 0) set_d(1, ro_d, rs_d, rsrc_d);
         else d_valid = 0;
         id_ready = ($urandom_range(0, 3) != 0);
         #1;
         blk = exp_block();
         checks++;
         if (oa_valid !== (a_valid && !blk) || ia_ready !== (oa_ready && !blk)
             || io_inflight !== 5'(m_infl) || io_error !== m_err
             || oa_data !== a_data || oa_src !== a_src || id_valid !== d_valid) begin
            errors++;
            $display("FAIL rand_c%0d: got v%0b r%0b n%0d e%0b want v%0b r%0b n%0d e%0b",
                     c, oa_valid, ia_ready, io_inflight, io_error,
                     a_valid && !blk, oa_ready && !blk, m_infl, m_err);
         end
         af = a_valid && oa_ready && !blk;
         df = d_valid && id_ready;
         tick;
         if (af) a_left--;
         if (df) d_left--;
      end
      a_valid = 0; d_valid = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_same_source;
      test_max_inflight;
      test_putfull_burst;
      test_d_burst;
      test_error;
      test_reset_mid_burst;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
